// File: rtl/logic_unit_rsp.sv
// Handshaked 32-bit logic unit (NOR/AND/OR/XOR) with an in-order result FIFO.
// Optional feature macro: LOGIC_RSP_STATS_EN adds the op_count accepted-request counter.
module logic_unit_rsp #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [1:0]                 op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out,
  output logic [1:0]                 out_op,
  output logic [$clog2(DEPTH):0]     level
`ifdef LOGIC_RSP_STATS_EN
  ,
  output logic [31:0]                op_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] LVL_ONE  = LW'(1'b1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

  function automatic logic [WIDTH-1:0] logic_fn(input logic [1:0] f,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    case (f)
      2'b00:   logic_fn = ~(x | y);
      2'b01:   logic_fn = x & y;
      2'b10:   logic_fn = x | y;
      2'b11:   logic_fn = x ^ y;
      default: logic_fn = {WIDTH{1'b0}};
    endcase
  endfunction

  logic [WIDTH-1:0] mem_res_r [DEPTH];
  logic [1:0]       mem_op_r  [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             push_s;
  logic             pop_s;

  // Handshake decode; both sides depend only on the occupancy register.
  always_comb begin
    in_ready  = (level_r != LVL_FULL);
    out_valid = (level_r != LVL_ZERO);
    push_s    = in_valid && in_ready;
    pop_s     = out_valid && out_ready;
    level     = level_r;
  end

  // Head-of-FIFO presentation, zeroed while empty.
  always_comb begin
    out    = {WIDTH{1'b0}};
    out_op = 2'b00;
    if (out_valid) begin
      out    = mem_res_r[rd_ptr_r];
      out_op = mem_op_r[rd_ptr_r];
    end else begin
      out    = {WIDTH{1'b0}};
      out_op = 2'b00;
    end
  end

  // Result storage; contents are don't-care until counted by level_r.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_res_r[wr_ptr_r] <= logic_fn(op, a, b);
      mem_op_r[wr_ptr_r]  <= op;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= LVL_ZERO;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

`ifdef LOGIC_RSP_STATS_EN
  // Accepted-request counter, wraps at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= 32'd0;
    end else if (push_s) begin
      op_count <= op_count + 32'd1;
    end else begin
      op_count <= op_count;
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_rsp.sv
// Scoreboard bench for logic_unit_rsp: directed requests queue expected results,
// an independent monitor pops and compares on every consumed output.
module tb_logic_unit_rsp;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [1:0]  out_op;
  logic [2:0]  level;
`ifdef LOGIC_RSP_STATS_EN
  logic [31:0] op_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  logic_unit_rsp #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_op(out_op), .level(level)
`ifdef LOGIC_RSP_STATS_EN
    , .op_count(op_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every consumed result against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [33:0] e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h/%0d expected none", out, out_op);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out, e[33:2]);
        chk("out_op", {30'd0, out_op}, {30'd0, e[1:0]});
      end
    end
  end

  // Present one request, wait (bounded) for acceptance, then record its expectation.
  task automatic send(input logic [31:0] av, input logic [31:0] bv,
                      input logic [1:0] ov, input logic [31:0] ev);
    bit done = 1'b0;
    in_valid = 1'b1; a = av; b = bv; op = ov;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        exp_q.push_back({ev, ov});
        done = 1'b1;
      end else begin
        @(posedge clk);
      end
    end
    #1;
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 20 cycles");
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: {a, b, op, expected}
  logic [31:0] va [12];
  logic [31:0] vb [12];
  logic [1:0]  vo [12];
  logic [31:0] ve [12];

  initial begin
    va[0]  = 32'hFFFF0000; vb[0]  = 32'h00FF00FF; vo[0]  = 2'b00; ve[0]  = 32'h0000FF00;
    va[1]  = 32'hFFFF0000; vb[1]  = 32'h00FF00FF; vo[1]  = 2'b01; ve[1]  = 32'h00FF0000;
    va[2]  = 32'hFFFF0000; vb[2]  = 32'h00FF00FF; vo[2]  = 2'b10; ve[2]  = 32'hFFFF00FF;
    va[3]  = 32'hFFFF0000; vb[3]  = 32'h00FF00FF; vo[3]  = 2'b11; ve[3]  = 32'hFF0000FF;
    va[4]  = 32'h12345678; vb[4]  = 32'h0F0F0F0F; vo[4]  = 2'b00; ve[4]  = 32'hE0C0A080;
    va[5]  = 32'h12345678; vb[5]  = 32'h0F0F0F0F; vo[5]  = 2'b01; ve[5]  = 32'h02040608;
    va[6]  = 32'h12345678; vb[6]  = 32'h0F0F0F0F; vo[6]  = 2'b10; ve[6]  = 32'h1F3F5F7F;
    va[7]  = 32'h12345678; vb[7]  = 32'h0F0F0F0F; vo[7]  = 2'b11; ve[7]  = 32'h1D3B5977;
    va[8]  = 32'hAAAAAAAA; vb[8]  = 32'h55555555; vo[8]  = 2'b00; ve[8]  = 32'h00000000;
    va[9]  = 32'hAAAAAAAA; vb[9]  = 32'h55555555; vo[9]  = 2'b01; ve[9]  = 32'h00000000;
    va[10] = 32'hAAAAAAAA; vb[10] = 32'h55555555; vo[10] = 2'b10; ve[10] = 32'hFFFFFFFF;
    va[11] = 32'hAAAAAAAA; vb[11] = 32'h55555555; vo[11] = 2'b11; ve[11] = 32'hFFFFFFFF;
  end

  // Basic ops on a=0xA, b=0xC
  logic [31:0] basic_e [4];
  initial begin
    basic_e[0] = 32'hFFFFFFF1; basic_e[1] = 32'h00000008;
    basic_e[2] = 32'h0000000E; basic_e[3] = 32'h00000006;
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 32'd0; b = 32'd0; op = 2'b00;
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out", out, 32'd0);
    chk("reset_out_op", {30'd0, out_op}, 32'd0);
    chk("reset_level", {29'd0, level}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef LOGIC_RSP_STATS_EN
    chk("reset_op_count", op_count, 32'd0);
`endif

    // Single ops, one-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(32'h0000000A, 32'h0000000C, 2'(i), basic_e[i]);
      chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
      chk("latency_level", {29'd0, level}, 32'd1);
      cycle();
      chk("single_drained", {29'd0, level}, 32'd0);
    end

    // Fill with consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h0000000A, 32'h0000000C, 2'(i), basic_e[i]);
    chk("full_level", {29'd0, level}, 32'd4);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_head_stable", out, 32'hFFFFFFF1);
    in_valid = 1'b1; a = 32'h12345678; b = 32'h87654321; op = 2'b11;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("held_in_ready", {31'd0, in_ready}, 32'd0);
      chk("held_level", {29'd0, level}, 32'd4);
    end
    in_valid = 1'b0;

    // Drain in order
    out_ready = 1'b1;
    cycle();
    chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
    chk("drain_level3", {29'd0, level}, 32'd3);
    cycle(); cycle(); cycle();
    chk("drain_level0", {29'd0, level}, 32'd0);
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

    // Simultaneous push/pop at level 2, pointers wrap several times
    out_ready = 1'b0;
    send(va[0], vb[0], vo[0], ve[0]);
    send(va[1], vb[1], vo[1], ve[1]);
    chk("stream_prefill", {29'd0, level}, 32'd2);
    out_ready = 1'b1;
    for (int i = 2; i < 12; i++) begin
      send(va[i], vb[i], vo[i], ve[i]);
      chk("stream_level", {29'd0, level}, 32'd2);
    end
    for (int i = 0; i < 10 && level != 3'd0; i++) cycle();
    chk("stream_empty", {29'd0, level}, 32'd0);

    // Reset mid-operation
    rst = 1'b1; cycle(); rst = 1'b0;
    exp_q.delete();
    out_ready = 1'b0;
    for (int i = 4; i < 7; i++) send(va[i], vb[i], vo[i], ve[i]);
    chk("pre_rst_level", {29'd0, level}, 32'd3);
`ifdef LOGIC_RSP_STATS_EN
    chk("pre_rst_op_count", op_count, 32'd3);
`endif
    rst = 1'b1; cycle(); rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_level", {29'd0, level}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out", out, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef LOGIC_RSP_STATS_EN
    chk("mid_rst_op_count", op_count, 32'd0);
`endif

    // Post-reset sanity: new request flows normally
    out_ready = 1'b1;
    send(va[7], vb[7], vo[7], ve[7]);
    cycle(); cycle();
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
